// File: rtl/motor_ramp_sched.sv
// Two-channel PWM magnitude/direction ramp scheduler fed from a command FIFO.
// Each command is ramped to in STEP increments every TICK_DIV clocks.
module motor_ramp_sched #(
   parameter int TICK_DIV = 1000,
   parameter int STEP     = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cmd_data,
   input  logic        cmd_empty,
   output logic        cmd_rd_en,
   input  logic        estop,
   output logic [14:0] para_r,
   output logic [14:0] para_l,
   output logic        dir_r,
   output logic        dir_l,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_RAMP
   } state_t;

   localparam logic [15:0] C_STEP = 16'(STEP);
   localparam logic [15:0] C_LAST = 16'(TICK_DIV - 1);

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [14:0] r_para_r;
   logic [14:0] r_para_l;
   logic [14:0] r_tgt_r;
   logic [14:0] r_tgt_l;
   logic        r_dir_r;
   logic        r_dir_l;
   logic        r_tdir_r;
   logic        r_tdir_l;
   logic        r_rd_en;
   logic        r_busy;

   logic [15:0] w_nxt_r;
   logic [15:0] w_nxt_l;
   logic        w_tick;
   logic        w_settled;

   // Returns {dir, para} after one tick; 16-bit math so nothing wraps.
   function automatic logic [15:0] f_step(
      input logic [14:0] i_para,
      input logic        i_dir,
      input logic [14:0] i_tgt,
      input logic        i_tdir
   );
      logic [15:0] w_p;
      logic [15:0] w_t;
      logic [15:0] w_up;
      logic [15:0] w_dn;
      logic        w_d;
      w_p  = {1'b0, i_para};
      w_t  = {1'b0, i_tgt};
      w_up = w_p + C_STEP;
      w_dn = (w_p > C_STEP) ? (w_p - C_STEP) : 16'd0;
      w_d  = i_dir;
      if (i_dir != i_tdir) begin
         if (w_p != 16'd0) w_p = w_dn;
         else              w_d = i_tdir;
      end else if (w_p < w_t) begin
         w_p = (w_up < w_t) ? w_up : w_t;
      end else if (w_p > w_t) begin
         w_p = (w_dn > w_t) ? w_dn : w_t;
      end
      return {w_d, w_p[14:0]};
   endfunction

   assign w_nxt_r   = f_step(r_para_r, r_dir_r, r_tgt_r, r_tdir_r);
   assign w_nxt_l   = f_step(r_para_l, r_dir_l, r_tgt_l, r_tdir_l);
   assign w_tick    = (r_cnt == C_LAST);
   assign w_settled = (r_para_r == r_tgt_r) && (r_dir_r == r_tdir_r) &&
                      (r_para_l == r_tgt_l) && (r_dir_l == r_tdir_l);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= 16'd0;
         r_para_r <= 15'd0;
         r_para_l <= 15'd0;
         r_tgt_r  <= 15'd0;
         r_tgt_l  <= 15'd0;
         r_dir_r  <= 1'b0;
         r_dir_l  <= 1'b0;
         r_tdir_r <= 1'b0;
         r_tdir_l <= 1'b0;
         r_rd_en  <= 1'b0;
         r_busy   <= 1'b0;
      end else if (estop) begin
         // Kill drive, keep direction, and make the targets match so we rest.
         r_state  <= S_IDLE;
         r_cnt    <= 16'd0;
         r_para_r <= 15'd0;
         r_para_l <= 15'd0;
         r_tgt_r  <= 15'd0;
         r_tgt_l  <= 15'd0;
         r_tdir_r <= r_dir_r;
         r_tdir_l <= r_dir_l;
         r_rd_en  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (!cmd_empty) begin
                  r_state <= S_FETCH;
                  r_rd_en <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            S_FETCH: begin
               r_rd_en <= 1'b0;
               r_state <= S_LATCH;
            end
            S_LATCH: begin
               r_tdir_r <= cmd_data[0];
               r_tgt_r  <= cmd_data[15:1];
               r_tdir_l <= cmd_data[16];
               r_tgt_l  <= cmd_data[31:17];
               r_cnt    <= 16'd0;
               r_state  <= S_RAMP;
            end
            S_RAMP: begin
               if (w_settled) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= 16'd0;
               end else begin
                  r_cnt <= w_tick ? 16'd0 : (r_cnt + 16'd1);
                  if (w_tick) begin
                     r_dir_r  <= w_nxt_r[15];
                     r_para_r <= w_nxt_r[14:0];
                     r_dir_l  <= w_nxt_l[15];
                     r_para_l <= w_nxt_l[14:0];
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // The strobe is masked combinationally so the FIFO is never read under estop/rst.
   assign cmd_rd_en = r_rd_en & ~estop & ~rst;
   assign para_r    = r_para_r;
   assign para_l    = r_para_l;
   assign dir_r     = r_dir_r;
   assign dir_l     = r_dir_l;
   assign busy      = r_busy;

endmodule

// File: tb/tb_motor_ramp_sched.sv
// Scoreboard bench for motor_ramp_sched: every output change is popped
// against a queue of hand-computed events (values plus cycle spacing).
module tb_motor_ramp_sched;

   localparam int TD = 4;
   localparam int ST = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cmd_data = 32'd0;
   logic        cmd_empty = 1'b1;
   logic        cmd_rd_en;
   logic        estop = 1'b0;
   logic [14:0] para_r;
   logic [14:0] para_l;
   logic        dir_r;
   logic        dir_l;
   logic        busy;

   typedef struct {
      logic        rd;
      logic        bz;
      logic        dr;
      logic [14:0] pr;
      logic        dl;
      logic [14:0] pl;
      int          dt;
   } ev_t;

   ev_t         exp_q[$];
   logic [31:0] fq[$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          last_cyc = 0;
   logic [33:0] prev = '1;

   always #5 clk = ~clk;

   motor_ramp_sched #(.TICK_DIV(TD), .STEP(ST)) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_data (cmd_data),
      .cmd_empty(cmd_empty),
      .cmd_rd_en(cmd_rd_en),
      .estop    (estop),
      .para_r   (para_r),
      .para_l   (para_l),
      .dir_r    (dir_r),
      .dir_l    (dir_l),
      .busy     (busy)
   );

   // Standard (non first-word-fall-through) FIFO model.
   always @(posedge clk) begin
      if (cmd_rd_en && fq.size() > 0) cmd_data <= fq.pop_front();
   end

   always @(negedge clk) cmd_empty = (fq.size() == 0);

   function automatic logic [31:0] word(int pr, int dr, int pl, int dl);
      logic [14:0] a;
      logic [14:0] b;
      a = 15'(pr);
      b = 15'(pl);
      return {b, 1'(dl), a, 1'(dr)};
   endfunction

   task automatic expect_ev(int rd, int bz, int dr, int pr, int dl, int pl,
                            int dt);
      ev_t e;
      e.rd = 1'(rd);
      e.bz = 1'(bz);
      e.dr = 1'(dr);
      e.pr = 15'(pr);
      e.dl = 1'(dl);
      e.pl = 15'(pl);
      e.dt = dt;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      logic [33:0] snap;
      logic [33:0] want;
      ev_t         e;
      cyc++;
      if (rst) begin
         n_tests++;
         if (cmd_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_in_rst: cmd_rd_en=%b required 0", cmd_rd_en);
         end
      end
      if (estop) begin
         n_tests++;
         if (cmd_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_in_estop: cmd_rd_en=%b required 0", cmd_rd_en);
         end
      end
      snap = {cmd_rd_en, busy, dir_r, para_r, dir_l, para_l};
      if (snap !== prev) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got rd=%b busy=%b dr=%b pr=%0d dl=%b pl=%0d at cyc %0d, required no change",
                     cmd_rd_en, busy, dir_r, para_r, dir_l, para_l, cyc);
         end else begin
            e = exp_q.pop_front();
            want = {e.rd, e.bz, e.dr, e.pr, e.dl, e.pl};
            if (snap !== want || (e.dt >= 0 && (cyc - last_cyc) != e.dt)) begin
               n_fail++;
               $display("FAIL event: got rd=%b busy=%b dr=%b pr=%0d dl=%b pl=%0d dt=%0d, required rd=%b busy=%b dr=%b pr=%0d dl=%b pl=%0d dt=%0d",
                        cmd_rd_en, busy, dir_r, para_r, dir_l, para_l,
                        cyc - last_cyc, e.rd, e.bz, e.dr, e.pr, e.dl, e.pl,
                        e.dt);
            end
         end
         prev = snap;
         last_cyc = cyc;
      end
   end

   task automatic send(logic [31:0] w);
      @(posedge clk);
      #1;
      fq.push_back(w);
   endtask

   task automatic wait_done(string name);
      for (int i = 0; i < 20000 && exp_q.size() != 0; i++) @(posedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_timeout: %0d events pending, required 0", name,
                  exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(posedge clk);
   endtask

   initial begin
      int v;
      bit hit;
      // Reset with a word already waiting; then ramp right to 40.
      fq.push_back(word(40, 0, 0, 0));
      expect_ev(0, 0, 0, 0, 0, 0, -1);
      expect_ev(1, 1, 0, 0, 0, 0, -1);
      expect_ev(0, 1, 0, 0, 0, 0, 1);
      expect_ev(0, 1, 0, 16, 0, 0, 5);
      expect_ev(0, 1, 0, 32, 0, 0, 4);
      expect_ev(0, 1, 0, 40, 0, 0, 4);
      expect_ev(0, 0, 0, 40, 0, 0, 1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      wait_done("single");

      // Down to 32, then reverse to 16 in the other direction.
      expect_ev(1, 1, 0, 40, 0, 0, -1);
      expect_ev(0, 1, 0, 40, 0, 0, 1);
      expect_ev(0, 1, 0, 32, 0, 0, 5);
      expect_ev(0, 0, 0, 32, 0, 0, 1);
      send(word(32, 0, 0, 0));
      wait_done("down");
      expect_ev(1, 1, 0, 32, 0, 0, -1);
      expect_ev(0, 1, 0, 32, 0, 0, 1);
      expect_ev(0, 1, 0, 16, 0, 0, 5);
      expect_ev(0, 1, 0, 0, 0, 0, 4);
      expect_ev(0, 1, 1, 0, 0, 0, 4);
      expect_ev(0, 1, 1, 16, 0, 0, 4);
      expect_ev(0, 0, 1, 16, 0, 0, 1);
      send(word(16, 1, 0, 0));
      wait_done("reverse");

      // Long left ramp to 32760, then the clamp at 32767.
      expect_ev(1, 1, 1, 16, 0, 0, -1);
      expect_ev(0, 1, 1, 16, 0, 0, 1);
      for (int k = 1; k <= 2048; k++) begin
         v = 16 * k;
         if (v > 32760) v = 32760;
         expect_ev(0, 1, 1, 16, 0, v, (k == 1) ? 5 : 4);
      end
      expect_ev(0, 0, 1, 16, 0, 32760, 1);
      send(word(16, 1, 32760, 0));
      wait_done("long");
      expect_ev(1, 1, 1, 16, 0, 32760, -1);
      expect_ev(0, 1, 1, 16, 0, 32760, 1);
      expect_ev(0, 1, 1, 16, 0, 32767, 5);
      expect_ev(0, 0, 1, 16, 0, 32767, 1);
      send(word(16, 1, 32767, 0));
      wait_done("clamp_hi");

      // Small downward steps that clamp at the target.
      expect_ev(1, 1, 1, 16, 0, 32767, -1);
      expect_ev(0, 1, 1, 16, 0, 32767, 1);
      expect_ev(0, 1, 1, 10, 0, 32767, 5);
      expect_ev(0, 0, 1, 10, 0, 32767, 1);
      send(word(10, 1, 32767, 0));
      wait_done("to10");
      expect_ev(1, 1, 1, 10, 0, 32767, -1);
      expect_ev(0, 1, 1, 10, 0, 32767, 1);
      expect_ev(0, 1, 1, 5, 0, 32767, 5);
      expect_ev(0, 0, 1, 5, 0, 32767, 1);
      send(word(5, 1, 32767, 0));
      wait_done("clamp_lo");

      // Already-settled command leaves RAMP on its first cycle.
      expect_ev(1, 1, 1, 5, 0, 32767, -1);
      expect_ev(0, 1, 1, 5, 0, 32767, 1);
      expect_ev(0, 0, 1, 5, 0, 32767, 2);
      send(word(5, 1, 32767, 0));
      wait_done("settled");

      expect_ev(1, 1, 1, 5, 0, 32767, -1);
      expect_ev(0, 1, 1, 5, 0, 32767, 1);
      expect_ev(0, 1, 1, 16, 0, 32767, 5);
      expect_ev(0, 0, 1, 16, 0, 32767, 1);
      send(word(16, 1, 32767, 0));
      wait_done("to16");

      // estop once para_r reaches 32, with a command waiting in the FIFO.
      expect_ev(1, 1, 1, 16, 0, 32767, -1);
      expect_ev(0, 1, 1, 16, 0, 32767, 1);
      expect_ev(0, 1, 1, 32, 0, 32767, 5);
      expect_ev(0, 0, 1, 0, 0, 0, 2);
      send(word(64, 1, 32767, 0));
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (para_r == 15'd32) begin
            hit = 1'b1;
            break;
         end
      end
      n_tests++;
      if (!hit) begin
         n_fail++;
         $display("FAIL estop_arm: para_r=%0d required 32", para_r);
      end
      @(posedge clk);
      #1;
      estop = 1'b1;
      fq.push_back(word(0, 0, 0, 0));
      expect_ev(1, 1, 1, 0, 0, 0, -1);
      expect_ev(0, 1, 1, 0, 0, 0, 1);
      expect_ev(0, 1, 0, 0, 0, 0, 5);
      expect_ev(0, 0, 0, 0, 0, 0, 1);
      repeat (8) @(posedge clk);
      #1;
      estop = 1'b0;
      wait_done("estop_flip");

      // Two queued commands: second fetch only after IDLE.
      expect_ev(1, 1, 0, 0, 0, 0, -1);
      expect_ev(0, 1, 0, 0, 0, 0, 1);
      expect_ev(0, 1, 0, 16, 0, 0, 5);
      expect_ev(0, 0, 0, 16, 0, 0, 1);
      expect_ev(1, 1, 0, 16, 0, 0, 1);
      expect_ev(0, 1, 0, 16, 0, 0, 1);
      expect_ev(0, 1, 0, 16, 1, 0, 5);
      expect_ev(0, 1, 0, 16, 1, 16, 4);
      expect_ev(0, 0, 0, 16, 1, 16, 1);
      @(posedge clk);
      #1;
      fq.push_back(word(16, 0, 0, 0));
      fq.push_back(word(16, 0, 16, 1));
      wait_done("queued");

      // Empty FIFO: nothing may move.
      repeat (20) @(posedge clk);
      n_tests++;
      if (exp_q.size() != 0 || fq.size() != 0) begin
         n_fail++;
         $display("FAIL drain: exp=%0d fifo=%0d required 0 0", exp_q.size(),
                  fq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
